rx_serial_7e1: RTL and testbench

RX_SERIAL_7E1 -- requirements
Module: rx_serial_7e1

---
 rtl/rx_serial_pkg.sv | 26 ++
 rtl/contador_m.sv | 39 +++
 rtl/rx_serial_7e1.sv | 197 +++++++++++++++++++
 tb/tb_rx_serial_7e1.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_serial_pkg.sv
// rx_serial_pkg
// Shared definitions for the 7E1 serial receiver and its matching transmitter:
// default bit timing (50 MHz clock, 115200 baud), data word width and the
// receiver FSM state encoding, which is also exported on db_estado.
package rx_serial_pkg;

  localparam int CICLOS_BIT_PADRAO = 434;  // clock cycles per bit
  localparam int MEIO_BIT_PADRAO   = 217;  // start edge to mid-bit sample
  localparam int N_DADOS           = 7;    // data bits per word

  typedef enum logic [2:0] {
    INICIAL         = 3'd0,
    CONFIRMA_START  = 3'd1,
    RECEBE_DADOS    = 3'd2,
    RECEBE_PARIDADE = 3'd3,
    RECEBE_STOP     = 3'd4,
    ARMAZENA        = 3'd5
  } estado_t;

  // Even parity check: data bits plus parity bit must XOR to zero.
  function automatic logic paridade_par_ok(input logic [N_DADOS-1:0] dados,
                                           input logic               bit_par);
    return ~((^dados) ^ bit_par);
  endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m
// Modulo-M counter used for bit timing.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high reset (count to 0)
//   zera   - synchronous clear, has priority over conta
//   conta  - count enable; wraps from M-1 back to 0
//   fim    - count is at M-1 (last cycle of a bit period)
//   meio   - count is at MEIO-1 (half-bit point after a clear)
module contador_m #(
  parameter int M    = 434,
  parameter int MEIO = 217,
  parameter int N    = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim,
  output logic meio
);

  localparam logic [N-1:0] ULTIMO   = N'(M - 1);
  localparam logic [N-1:0] PTO_MEIO = N'(MEIO - 1);

  logic [N-1:0] r_q;

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      r_q <= '0;
    end else if (conta) begin
      r_q <= (r_q == ULTIMO) ? '0 : r_q + 1'b1;
    end
  end

  assign fim  = (r_q == ULTIMO);
  assign meio = (r_q == PTO_MEIO);

endmodule

// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1
// Asynchronous serial receiver, frame = start(0), 7 data bits LSB first,
// even parity, 1 stop(1).
// Ports:
//   clock          - system clock (single domain)
//   reset          - synchronous active-high reset
//   dado_serial    - asynchronous serial line, idle high
//   limpa          - consumer acknowledge, clears tem_dado
//   dado_recebido  - last received 7-bit word
//   paridade_ok    - even parity of the last word was correct
//   erro_frame     - stop bit of the last word was sampled low
//   pronto         - one-cycle pulse when a word completes
//   tem_dado       - an unread word is held
//   sobrescrita    - sticky overrun flag, cleared only by reset
//   db_estado      - current FSM state (debug)
module rx_serial_7e1
  import rx_serial_pkg::*;
#(
  parameter int CICLOS_BIT = CICLOS_BIT_PADRAO,
  parameter int MEIO_BIT   = MEIO_BIT_PADRAO
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         dado_serial,
  input  logic         limpa,
  output logic [6:0]   dado_recebido,
  output logic         paridade_ok,
  output logic         erro_frame,
  output logic         pronto,
  output logic         tem_dado,
  output logic         sobrescrita,
  output logic [2:0]   db_estado
);

  localparam logic [2:0] ULTIMO_BIT = 3'(N_DADOS - 1);

  // Two-flop synchronizer, idle (high) after reset.
  logic [1:0] r_sinc;
  logic       w_rx;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sinc <= 2'b11;
    end else begin
      r_sinc <= {r_sinc[0], dado_serial};
    end
  end

  assign w_rx = r_sinc[1];

  // Bit timing
  logic w_zera, w_conta, w_fim, w_meio;

  contador_m #(
    .M    (CICLOS_BIT),
    .MEIO (MEIO_BIT)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .zera  (w_zera),
    .conta (w_conta),
    .fim   (w_fim),
    .meio  (w_meio)
  );

  // FSM state register
  estado_t r_estado, w_estado_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado <= INICIAL;
    end else begin
      r_estado <= w_estado_next;
    end
  end

  // Datapath registers
  logic [N_DADOS-1:0] r_desloc;
  logic [2:0]         r_cont_bits;
  logic               r_bit_par;
  logic               r_erro_stop;
  logic               r_espera_alto;
  logic [N_DADOS-1:0] r_dado;
  logic               r_paridade_ok;
  logic               r_erro_frame;
  logic               r_tem_dado;
  logic               r_sobrescrita;

  logic w_desloca, w_amostra_par, w_amostra_stop, w_armazena;

  // Next state and datapath strobes
  always_comb begin
    w_estado_next  = r_estado;
    w_zera         = 1'b0;
    w_conta        = 1'b0;
    w_desloca      = 1'b0;
    w_amostra_par  = 1'b0;
    w_amostra_stop = 1'b0;
    w_armazena     = 1'b0;
    case (r_estado)
      INICIAL: begin
        w_zera = 1'b1;
        if (!w_rx) w_estado_next = CONFIRMA_START;
      end
      CONFIRMA_START: begin
        w_conta = 1'b1;
        if (r_espera_alto) begin
          // Line still low after a framing error (break): do not start a
          // new word until the line has been seen high in INICIAL.
          w_estado_next = INICIAL;
        end else if (w_meio) begin
          // Clear here so the next sample lands exactly CICLOS_BIT later.
          w_zera        = 1'b1;
          w_estado_next = w_rx ? INICIAL : RECEBE_DADOS;
        end
      end
      RECEBE_DADOS: begin
        w_conta = 1'b1;
        if (w_fim) begin
          w_desloca = 1'b1;
          if (r_cont_bits == ULTIMO_BIT) w_estado_next = RECEBE_PARIDADE;
        end
      end
      RECEBE_PARIDADE: begin
        w_conta = 1'b1;
        if (w_fim) begin
          w_amostra_par = 1'b1;
          w_estado_next = RECEBE_STOP;
        end
      end
      RECEBE_STOP: begin
        w_conta = 1'b1;
        if (w_fim) begin
          w_amostra_stop = 1'b1;
          w_estado_next  = ARMAZENA;
        end
      end
      ARMAZENA: begin
        w_armazena    = 1'b1;
        w_zera        = 1'b1;
        w_estado_next = INICIAL;
      end
      default: begin
        w_estado_next = INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_desloc      <= '0;
      r_cont_bits   <= '0;
      r_bit_par     <= 1'b0;
      r_erro_stop   <= 1'b0;
      r_espera_alto <= 1'b0;
      r_dado        <= '0;
      r_paridade_ok <= 1'b0;
      r_erro_frame  <= 1'b0;
      r_tem_dado    <= 1'b0;
      r_sobrescrita <= 1'b0;
    end else begin
      if (w_desloca) begin
        // LSB arrives first, so shift in from the top.
        r_desloc    <= {w_rx, r_desloc[N_DADOS-1:1]};
        r_cont_bits <= (r_cont_bits == ULTIMO_BIT) ? 3'd0 : r_cont_bits + 3'd1;
      end
      if (w_amostra_par)  r_bit_par   <= w_rx;
      if (w_amostra_stop) r_erro_stop <= ~w_rx;

      if (w_armazena) begin
        r_dado        <= r_desloc;
        r_paridade_ok <= paridade_par_ok(r_desloc, r_bit_par);
        r_erro_frame  <= r_erro_stop;
        r_espera_alto <= r_erro_stop;
      end else if (r_estado == INICIAL && w_rx) begin
        r_espera_alto <= 1'b0;
      end

      // A store wins over a simultaneous acknowledge: the new word is unread.
      if (w_armazena) begin
        r_tem_dado <= 1'b1;
        if (r_tem_dado && !limpa) r_sobrescrita <= 1'b1;
      end else if (limpa && r_tem_dado) begin
        r_tem_dado <= 1'b0;
      end
    end
  end

  assign dado_recebido = r_dado;
  assign paridade_ok   = r_paridade_ok;
  assign erro_frame    = r_erro_frame;
  assign pronto        = w_armazena;
  assign tem_dado      = r_tem_dado;
  assign sobrescrita   = r_sobrescrita;
  assign db_estado     = r_estado;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// tb_rx_serial_7e1
// Directed bench for rx_serial_7e1 with short bit timing (16 cycles/bit).
module tb_rx_serial_7e1;

  localparam int C = 16;           // cycles per bit
  localparam int M = 8;            // half-bit
  localparam int LAT_MAX = (C * 19) / 2 + 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       dado_serial;
  logic       limpa;
  logic [6:0] dado_recebido;
  logic       paridade_ok;
  logic       erro_frame;
  logic       pronto;
  logic       tem_dado;
  logic       sobrescrita;
  logic [2:0] db_estado;

  rx_serial_7e1 #(
    .CICLOS_BIT (C),
    .MEIO_BIT   (M)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dado_serial   (dado_serial),
    .limpa         (limpa),
    .dado_recebido (dado_recebido),
    .paridade_ok   (paridade_ok),
    .erro_frame    (erro_frame),
    .pronto        (pronto),
    .tem_dado      (tem_dado),
    .sobrescrita   (sobrescrita),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pronto   = 0;
  int cyc_pronto = 0;
  always @(negedge clock) begin
    if (pronto === 1'b1) begin
      n_pronto   = n_pronto + 1;
      cyc_pronto = cyc;
    end
  end

  int   checks   = 0;
  int   failures = 0;
  int   cyc_borda;
  int   p0;
  logic got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input logic b);
    dado_serial = b;
    repeat (C) @(negedge clock);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic par, input logic stop);
    cyc_borda = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
    dado_serial = 1'b1;
  endtask

  task automatic pulse_limpa();
    limpa = 1'b1;
    idle(1);
    limpa = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
  endtask

  initial begin
    reset       = 1'b1;
    dado_serial = 1'b1;
    limpa       = 1'b0;
    got         = 1'b0;
    idle(3);
    chk("rst_estado",  db_estado, 0);
    chk("rst_dado",    dado_recebido, 0);
    chk("rst_par_ok",  paridade_ok, 0);
    chk("rst_erro",    erro_frame, 0);
    chk("rst_pronto",  pronto, 0);
    chk("rst_tem",     tem_dado, 0);
    chk("rst_sob",     sobrescrita, 0);
    reset = 1'b0;
    idle(2);

    // Acknowledge with nothing held is ignored
    pulse_limpa();
    chk("limpa_vazio_tem", tem_dado, 0);
    chk("limpa_vazio_sob", sobrescrita, 0);

    // Scenario 1: 0x41, correct parity (two ones -> 0), good stop
    p0 = n_pronto;
    send_frame(7'h41, 1'b0, 1'b1);
    idle(5);
    chk("s1_dado",    dado_recebido, 7'h41);
    chk("s1_par_ok",  paridade_ok, 1);
    chk("s1_erro",    erro_frame, 0);
    chk("s1_pronto",  n_pronto - p0, 1);
    chk("s1_tem",     tem_dado, 1);
    chk("s1_latency_ok", (cyc_pronto - cyc_borda) <= LAT_MAX, 1);
    pulse_limpa();
    chk("s1_limpa_tem", tem_dado, 0);
    chk("s1_dado_estavel", dado_recebido, 7'h41);

    // Scenario 2: 0x55 (four ones) with parity forced to 1
    send_frame(7'h55, 1'b1, 1'b1);
    idle(5);
    chk("s2_dado",   dado_recebido, 7'h55);
    chk("s2_par_ok", paridade_ok, 0);
    chk("s2_erro",   erro_frame, 0);
    pulse_limpa();

    // Scenario 3: 0x7F (seven ones -> parity 1) with stop driven low
    p0 = n_pronto;
    send_frame(7'h7F, 1'b1, 1'b0);
    idle(5);
    chk("s3_dado",   dado_recebido, 7'h7F);
    chk("s3_erro",   erro_frame, 1);
    chk("s3_par_ok", paridade_ok, 1);
    chk("s3_pronto", n_pronto - p0, 1);
    pulse_limpa();
    idle(20);
    chk("s3_estado_ocioso", db_estado, 0);

    // Scenario 4: short low glitch is a false start
    p0 = n_pronto;
    dado_serial = 1'b0;
    idle(4);
    chk("s4_confirma", db_estado, 1);
    dado_serial = 1'b1;
    idle(M + 3);
    chk("s4_volta_inicial", db_estado, 0);
    idle(200);
    chk("s4_sem_pronto", n_pronto - p0, 0);

    // Scenario 5a: back-to-back 0x31, 0x32 without acknowledge
    p0 = n_pronto;
    send_frame(7'h31, 1'b1, 1'b1);
    send_frame(7'h32, 1'b1, 1'b1);
    idle(5);
    chk("s5a_pronto", n_pronto - p0, 2);
    chk("s5a_dado",   dado_recebido, 7'h32);
    chk("s5a_sob",    sobrescrita, 1);
    chk("s5a_tem",    tem_dado, 1);
    pulse_limpa();
    chk("s5a_sob_sticky", sobrescrita, 1);
    chk("s5a_limpa_tem",  tem_dado, 0);

    // Scenario 5b: same, acknowledge lands on the second store cycle
    do_reset();
    chk("s5b_sob_reset", sobrescrita, 0);
    send_frame(7'h31, 1'b1, 1'b1);
    got = 1'b0;
    fork
      send_frame(7'h32, 1'b1, 1'b1);
      begin
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clock);
          if (pronto === 1'b1) begin
            limpa = 1'b1;
            @(negedge clock);
            limpa = 1'b0;
            got = 1'b1;
          end
        end
      end
    join
    idle(5);
    chk("s5b_pronto_visto", got, 1);
    chk("s5b_sob",  sobrescrita, 0);
    chk("s5b_tem",  tem_dado, 1);
    chk("s5b_dado", dado_recebido, 7'h32);

    // Scenario 6: reset during data bits of 0x2A, then 0x13
    do_reset();
    p0 = n_pronto;
    drive_bit(1'b0);   // start
    drive_bit(1'b0);   // bit 0 of 0x2A
    drive_bit(1'b1);   // bit 1
    reset       = 1'b1;
    dado_serial = 1'b1;
    idle(1);
    chk("s6_estado_reset", db_estado, 0);
    idle(2);
    reset = 1'b0;
    idle(40);
    chk("s6_sem_pronto", n_pronto - p0, 0);
    chk("s6_dado_zero",  dado_recebido, 0);
    send_frame(7'h13, 1'b1, 1'b1);
    idle(5);
    chk("s6_dado",   dado_recebido, 7'h13);
    chk("s6_pronto", n_pronto - p0, 1);
    chk("s6_par_ok", paridade_ok, 1);

    // Break: line held low for many bit times
    pulse_limpa();
    p0 = n_pronto;
    dado_serial = 1'b0;
    idle(15 * C);
    chk("brk_estado_espera", db_estado <= 3'd1, 1);
    chk("brk_pronto", n_pronto - p0, 1);
    chk("brk_dado",   dado_recebido, 0);
    chk("brk_erro",   erro_frame, 1);
    chk("brk_par_ok", paridade_ok, 1);
    dado_serial = 1'b1;
    idle(20);
    chk("brk_estado_ocioso", db_estado, 0);
    send_frame(7'h41, 1'b0, 1'b1);
    idle(5);
    chk("brk_rec_dado",   dado_recebido, 7'h41);
    chk("brk_rec_erro",   erro_frame, 0);
    chk("brk_rec_pronto", n_pronto - p0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
